// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared types and default constants for the push-button
//               count-enable front end.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    // Debounce / press-tracking FSM states
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } btn_state_e;

    // Default parameter values (about 100 MHz: ~160 ns debounce, 50 ms / 10 ms repeat)
    localparam int c_DEBOUNCE_CYCLES_DEF = 16;
    localparam int c_REPEAT_DELAY_DEF    = 5_000_000;
    localparam int c_REPEAT_PERIOD_DEF   = 1_000_000;

    // Largest of three values, used to size the shared timer
    function automatic int btn_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a single asynchronous input bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_sync,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; second flop gives it a cycle to settle
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/btn_cnt_en_gen.sv
`default_nettype none
// ============================================================================
// Module      : btn_cnt_en_gen
// Description : Synchronises and debounces a raw push-button and emits
//               single-cycle count-enable pulses per press, with optional
//               auto-repeat while the button is held.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_cnt_en_gen
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = c_REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = c_REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst_sync,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic cnt_en,
    output logic btn_level
);

    // Timer must be able to hold the largest terminal count without wrapping
    localparam int c_TMAX = btn_max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int c_TW   = $clog2(c_TMAX + 1);

    // Debounce accepts when the timer has counted DEBOUNCE_CYCLES steps past entry;
    // together with the 2-flop synchroniser this places the output change
    // DEBOUNCE_CYCLES+3 edges after the raw input first changes.
    localparam logic [c_TW-1:0] c_DEB_T = c_TW'(DEBOUNCE_CYCLES);
    // Repeat terminals are one less than the spacing because the pulse is registered
    localparam logic [c_TW-1:0] c_DLY_T = c_TW'(REPEAT_DELAY - 1);
    localparam logic [c_TW-1:0] c_PER_T = c_TW'(REPEAT_PERIOD - 1);
    localparam logic [c_TW-1:0] c_SAT   = c_TW'(c_TMAX);

    logic            w_btn_s;
    btn_state_e      r_state;
    btn_state_e      w_next_state;
    logic [c_TW-1:0] r_timer;
    logic            r_phase;        // 0: waiting initial delay, 1: periodic repeat
    logic            w_phase_next;
    logic            w_timer_clr;
    logic            w_timer_inc;
    logic            w_pulse;
    logic            r_cnt_en;
    logic            r_btn_level;

    sync_2ff u_sync (
        .clk      (clk),
        .rst_sync (rst_sync),
        .d        (btn_raw),
        .q        (w_btn_s)
    );

    // State register and repeat-phase flag
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_state <= IDLE;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_phase <= w_phase_next;
        end
    end

    // Next-state, timer control and pulse decode
    always_comb begin
        w_next_state = r_state;
        w_phase_next = r_phase;
        w_timer_clr  = 1'b0;
        w_timer_inc  = 1'b0;
        w_pulse      = 1'b0;
        case (r_state)
            IDLE: begin
                w_timer_clr = 1'b1;
                if (w_btn_s) begin
                    w_next_state = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (!w_btn_s) begin
                    w_next_state = IDLE;
                    w_timer_clr  = 1'b1;
                end else if (r_timer == c_DEB_T) begin
                    w_next_state = PRESSED;
                    w_timer_clr  = 1'b1;
                    w_pulse      = 1'b1;
                end else begin
                    w_timer_inc  = 1'b1;
                end
            end
            PRESSED: begin
                // Release wins over a coincident repeat boundary
                if (!w_btn_s) begin
                    w_next_state = DEB_RELEASE;
                    w_timer_clr  = 1'b1;
                end else if (!repeat_en) begin
                    // Holding at zero makes a later 0->1 restart the full delay
                    w_timer_clr  = 1'b1;
                    w_phase_next = 1'b0;
                end else if (r_timer == (r_phase ? c_PER_T : c_DLY_T)) begin
                    w_timer_clr  = 1'b1;
                    w_pulse      = 1'b1;
                    w_phase_next = 1'b1;
                end else begin
                    w_timer_inc  = 1'b1;
                end
            end
            DEB_RELEASE: begin
                if (w_btn_s) begin
                    w_next_state = PRESSED;
                    w_timer_clr  = 1'b1;
                end else if (r_timer == c_DEB_T) begin
                    w_next_state = IDLE;
                    w_timer_clr  = 1'b1;
                end else begin
                    w_timer_inc  = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_timer_clr  = 1'b1;
            end
        endcase
        // Any state change restarts the repeat sequence from the initial delay
        if (w_next_state != r_state) begin
            w_phase_next = 1'b0;
        end
    end

    // Shared timer: cleared on request, otherwise saturating increment
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_timer <= '0;
        end else if (w_timer_clr) begin
            r_timer <= '0;
        end else if (w_timer_inc && (r_timer != c_SAT)) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Registered outputs, decoded from the upcoming state so level and pulse align
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_cnt_en    <= 1'b0;
            r_btn_level <= 1'b0;
        end else begin
            r_cnt_en    <= w_pulse;
            r_btn_level <= (w_next_state == PRESSED) || (w_next_state == DEB_RELEASE);
        end
    end

    assign cnt_en    = r_cnt_en;
    assign btn_level = r_btn_level;

endmodule
`default_nettype wire

// File: tb/tb_btn_cnt_en_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_cnt_en_gen
// Description : Directed self-checking bench for btn_cnt_en_gen
//               (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_cnt_en_gen;

    localparam int c_DEB = 4;
    localparam int c_LAT = c_DEB + 3;   // edges from raw change to output change

    logic clk;
    logic rst_sync;
    logic btn_raw;
    logic repeat_en;
    logic cnt_en;
    logic btn_level;

    int   n_vec;
    int   n_err;

    // Reference 4-bit counter driven by cnt_en
    logic       tb_clr;
    logic [3:0] tb_cnt;
    int         tb_carries;

    btn_cnt_en_gen #(
        .DEBOUNCE_CYCLES (c_DEB),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk       (clk),
        .rst_sync  (rst_sync),
        .btn_raw   (btn_raw),
        .repeat_en (repeat_en),
        .cnt_en    (cnt_en),
        .btn_level (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model: carry is the terminal-count enable (count 15 with cnt_en)
    always @(posedge clk) begin
        if (tb_clr) begin
            tb_cnt     <= 4'd0;
            tb_carries <= 0;
        end else if (cnt_en) begin
            tb_cnt <= tb_cnt + 4'd1;
            if (tb_cnt == 4'hF) tb_carries <= tb_carries + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_rep(input int off);
        return (off == 0) || (off == 20) || (off == 28) || (off == 36) ||
               (off == 44) || (off == 52);
    endfunction

    initial begin
        logic [8:0] pat;
        n_vec     = 0;
        n_err     = 0;
        rst_sync  = 1'b1;
        btn_raw   = 1'b0;
        repeat_en = 1'b0;
        tb_clr    = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("reset cnt_en", cnt_en, 0);
        chk("reset btn_level", btn_level, 0);
        rst_sync = 1'b0;
        tb_clr   = 1'b0;
        repeat (2) tick();

        // Clean press: one pulse after edge 7, level from the same cycle
        for (int i = 0; i < 30; i++) begin
            btn_raw = 1'b1;
            tick();
            chk($sformatf("press cnt_en @%0d", i), cnt_en, (i == c_LAT) ? 1 : 0);
            chk($sformatf("press level @%0d", i), btn_level, (i >= c_LAT) ? 1 : 0);
        end
        // Clean release
        for (int i = 0; i < 15; i++) begin
            btn_raw = 1'b0;
            tick();
            chk($sformatf("release level @%0d", i), btn_level, (i < c_LAT) ? 1 : 0);
            chk($sformatf("release cnt_en @%0d", i), cnt_en, 0);
        end

        // Bounce: 1,0,1,1,0,1,1,1,1 then held; last 0->1 at edge 5 -> pulse after edge 12
        pat = 9'b111101101;   // bit i applied at edge i
        for (int i = 0; i < 30; i++) begin
            btn_raw = (i < 9) ? pat[i] : 1'b1;
            tick();
            chk($sformatf("bounce cnt_en @%0d", i), cnt_en, (i == 12) ? 1 : 0);
        end
        for (int i = 0; i < 15; i++) begin
            btn_raw = 1'b0;
            tick();
        end
        chk("bounce released level", btn_level, 0);

        // Auto-repeat: pulses at offsets 0,20,28,36,44,52 from the first
        repeat_en = 1'b1;
        for (int i = 0; i < 67; i++) begin
            btn_raw = 1'b1;
            tick();
            chk($sformatf("repeat cnt_en @%0d", i - c_LAT), cnt_en,
                is_rep(i - c_LAT) ? 1 : 0);
        end
        chk("repeat level", btn_level, 1);

        // Reset mid-hold: outputs clear, fresh pulse 7 edges after deassert
        rst_sync = 1'b1;
        tick();
        chk("midrst cnt_en", cnt_en, 0);
        chk("midrst level", btn_level, 0);
        rst_sync = 1'b0;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk($sformatf("postrst cnt_en @%0d", i), cnt_en, (i == c_LAT) ? 1 : 0);
            chk($sformatf("postrst level @%0d", i), btn_level, (i >= c_LAT) ? 1 : 0);
        end

        // Release glitch: 2-cycle low while pressed changes nothing
        repeat_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            btn_raw = (i < 2) ? 1'b0 : 1'b1;
            tick();
            chk($sformatf("rglitch level @%0d", i), btn_level, 1);
            chk($sformatf("rglitch cnt_en @%0d", i), cnt_en, 0);
        end
        // Real release: level falls 7 edges after the low starts
        for (int i = 0; i < 15; i++) begin
            btn_raw = 1'b0;
            tick();
            chk($sformatf("rlow level @%0d", i), btn_level, (i < c_LAT) ? 1 : 0);
        end

        // Press glitch: 3-cycle high while idle changes nothing
        for (int i = 0; i < 15; i++) begin
            btn_raw = (i < 3) ? 1'b1 : 1'b0;
            tick();
            chk($sformatf("pglitch level @%0d", i), btn_level, 0);
            chk($sformatf("pglitch cnt_en @%0d", i), cnt_en, 0);
        end

        // Counter integration: 16 presses wrap the counter with exactly one carry
        tb_clr = 1'b1;
        tick();
        tb_clr = 1'b0;
        for (int p = 0; p < 16; p++) begin
            btn_raw = 1'b1;
            repeat (12) tick();
            btn_raw = 1'b0;
            repeat (12) tick();
        end
        chk("counter value", int'(tb_cnt), 0);
        chk("counter carries", tb_carries, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btn_cnt_en_gen.md
# btn_cnt_en_gen

Front-end stage that turns a raw, bouncing, asynchronous push-button into clean single-cycle count-enable pulses for the 4-bit synchronous counter. It synchronises the input, debounces both press and release, emits one pulse per accepted press, and optionally auto-repeats while the button is held. Its `cnt_en` output drives the counter's `cnt_en` input directly, on the same clock.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required to accept a press or a release. Must be ≥ 2.
- `REPEAT_DELAY`, default 5_000_000: cycles from the initial press pulse to the first repeat pulse. Must be ≥ 2.
- `REPEAT_PERIOD`, default 1_000_000: cycles between successive repeat pulses. Must be ≥ 2.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_sync` in 1: synchronous reset, active-high.
- `btn_raw` in 1: raw button, asynchronous, active-high.
- `repeat_en` in 1: synchronous auto-repeat enable.
- `cnt_en` out 1: one-cycle pulse per accepted press and per repeat; registered.
- `btn_level` out 1: debounced button level; registered.

## Operation

- **Synchroniser.** `btn_raw` passes through 2 flops to produce `btn_s`.
- **Shared timer.** One timer, width `$clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1)`. It is cleared on every state change. It never wraps; it saturates at its terminal count.
- **FSM states:** IDLE, DEB_PRESS, PRESSED, DEB_RELEASE.
- **IDLE:** `btn_level`=0. If `btn_s`=1, go to DEB_PRESS.
- **DEB_PRESS:**
  - `btn_s`=0 returns to IDLE with no pulse.
  - After `DEBOUNCE_CYCLES` consecutive high samples, go to PRESSED. `cnt_en`=1 for exactly the first cycle in PRESSED.
- **PRESSED:** `btn_level`=1.
  - With `repeat_en`=1, the timer counts. A pulse occurs at `REPEAT_DELAY` cycles after the initial pulse, then every `REPEAT_PERIOD` cycles.
  - With `repeat_en`=0, the timer is held at 0 and no repeat pulses occur.
  - A 0→1 transition of `repeat_en` restarts the delay: the next pulse comes `REPEAT_DELAY` cycles later.
  - `btn_s`=0 goes to DEB_RELEASE.
- **DEB_RELEASE:** `btn_level` stays 1 and no pulses are emitted.
  - `btn_s`=1 returns to PRESSED with no pulse; the repeat timer restarts from `REPEAT_DELAY`.
  - After `DEBOUNCE_CYCLES` consecutive low samples, go to IDLE.
- **Pulse spacing.** `cnt_en` is never high for 2 consecutive cycles.
- **Reset.** `rst_sync`=1 clears the synchroniser flops, the timer, `cnt_en`, and `btn_level`, and forces IDLE. Reset takes priority over all other events.
- **Reset mid-hold.** If reset occurs while the button is held, then after reset deasserts the held button is re-debounced from IDLE and yields a fresh pulse.

## Timing

- **Reset values:** `cnt_en`=0, `btn_level`=0, state=IDLE.
- **Press latency.** Take edge 0 as the first clock edge sampling `btn_raw`=1, with the input held high afterwards. `cnt_en` is high in the cycle following edge `DEBOUNCE_CYCLES+3`.
  - `btn_level` rises in the same cycle as `cnt_en`.
- **Release latency.** Take edge 0 as the first edge sampling `btn_raw`=0, with the input held low. `btn_level` falls in the cycle after edge `DEBOUNCE_CYCLES+3`.
- **Glitch rejection.** A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles, in either state, causes no output change.
- **Edge-case behaviour:**
  - A simultaneous repeat-pulse boundary and release (`btn_s`=0) suppresses the pulse.
  - `repeat_en` changing in the same cycle as the initial pulse has no effect on that pulse.

## Structure

- **Shared package `btn_pkg`:**
  - `btn_state_e` enum (IDLE, DEB_PRESS, PRESSED, DEB_RELEASE).
  - Default-parameter constants.
- **Sub-module `sync_2ff`:** the 2-flop synchroniser, with `clk`, `rst_sync`, `d`, `q`; reusable by other async inputs.
- **FSM, timer, and output registers:** all in `btn_cnt_en_gen`.

## Test plan

All scenarios use the bench parameters `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.

- **Clean press.** `btn_raw` goes 0→1 and is held 30 cycles with `repeat_en`=0 → exactly one `cnt_en` pulse, in the cycle after edge 7; `btn_level`=1 from the same cycle.
- **Bounce.** `btn_raw` toggles 1,0,1,1,0,1,1,1,1 then holds high → a single pulse, 7 edges after the last 0→1.
- **Auto-repeat.** Hold for 60 cycles after the first pulse with `repeat_en`=1 → pulses at offsets 0, 20, 28, 36, 44, 52 relative to the first pulse.
- **Release glitch.** While PRESSED, a 2-cycle low on `btn_raw` → `btn_level` stays 1 and no pulse occurs.
  - A subsequent 10-cycle low → `btn_level` falls 7 edges after the low starts.
- **Reset mid-hold.** Assert `rst_sync` for 1 cycle during repeat, with the button still held → outputs are 0 in the next cycle, and a new initial pulse appears 7 edges after reset deasserts.
- **Counter integration.** Drive the counter with this block's `cnt_en` and press 16 times → counter reads 0 and `carry` was observed high exactly once.
